// File: rtl/mseq_pkg.sv
// Shared types and helpers for the multi-channel M-sequence generator.
package mseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } mseq_state_e;

    localparam int MAX_ORDER = 32;

    function automatic logic [31:0] order_mask(input int order);
        if (order >= MAX_ORDER) begin
            return 32'hFFFF_FFFF;
        end else begin
            return (32'd1 << order) - 32'd1;
        end
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int amt, input int order);
        int a;
        a = amt % order;
        if (a == 0) begin
            return v & order_mask(order);
        end else begin
            return ((v << a) | (v >> (order - a))) & order_mask(order);
        end
    endfunction

    // Fibonacci step: feedback shifts in at bit 0, output is the MSB.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps,
                                              input int order);
        logic fb;
        fb = ^(s & taps & order_mask(order));
        return ((s << 1) | {31'd0, fb}) & order_mask(order);
    endfunction

    function automatic logic [31:0] prim_taps(input int order);
        case (order)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_D008;
            32:      return 32'h8020_0003;
            default: return (32'd3 << (order - 2)) & order_mask(order);
        endcase
    endfunction

endpackage

// File: rtl/mseq_lfsr_ch.sv
// One generator channel: state register plus a STEPS-deep unrolled advance.
// Zero-state recovery is compiled in with MSEQ_LOCKUP_RECOVER_EN.
module mseq_lfsr_ch
    import mseq_pkg::*;
#(
    parameter int ORDER  = 4,
    parameter int STEPS  = 1,
    parameter int CH_IDX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [ORDER-1:0] seed_i,
    input  logic [ORDER-1:0] taps_i,
    output logic [STEPS-1:0] bits_o,
`ifdef MSEQ_LOCKUP_RECOVER_EN
    output logic             zero_o,
`endif
    output logic             sop_o
);

`ifdef MSEQ_LOCKUP_RECOVER_EN
    localparam logic [ORDER-1:0] RELOAD = ORDER'(rotl(32'd1, CH_IDX, ORDER));
`endif

    logic [ORDER-1:0] state_q, state_d;
    logic [ORDER-1:0] seed_q;
    logic [ORDER-1:0] seed_rot_s;
    logic [ORDER-1:0] start_s;
    logic [ORDER-1:0] walk_s;
    logic [STEPS-1:0] bits_s;

    assign seed_rot_s = ORDER'(rotl(32'(seed_i), CH_IDX, ORDER));

    // Bits of the next word and the state after STEPS advances.
    always_comb begin
        start_s = state_q;
`ifdef MSEQ_LOCKUP_RECOVER_EN
        if (state_q == {ORDER{1'b0}}) begin
            start_s = RELOAD;
        end else begin
            start_s = state_q;
        end
`endif
        walk_s = start_s;
        bits_s = {STEPS{1'b0}};
        for (int k = 0; k < STEPS; k++) begin
            bits_s[k] = walk_s[ORDER-1];
            walk_s    = ORDER'(lfsr_step(32'(walk_s), 32'(taps_i), ORDER));
        end
    end

    // Next-state select: load has priority over advance.
    always_comb begin
        if (load_i) begin
            state_d = seed_rot_s;
        end else if (adv_i) begin
            state_d = walk_s;
        end else begin
            state_d = state_q;
        end
    end

    // State and latched-seed registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= {ORDER{1'b0}};
            seed_q  <= {ORDER{1'b0}};
        end else begin
            state_q <= state_d;
            if (load_i) begin
                seed_q <= seed_rot_s;
            end
        end
    end

    assign bits_o = bits_s;
    // Only channel 0 defines period alignment; others are neutral in the AND-reduce.
    assign sop_o  = (CH_IDX == 0) ? (state_q == seed_q) : 1'b1;
`ifdef MSEQ_LOCKUP_RECOVER_EN
    assign zero_o = (state_q == {ORDER{1'b0}});
`endif

endmodule

// File: rtl/mseq_gen_mc.sv
// Multi-channel, multi-bit-per-cycle M-sequence source with start/stop and valid/ready.
// Optional zero-state recovery: define MSEQ_LOCKUP_RECOVER_EN.
module mseq_gen_mc
    import mseq_pkg::*;
#(
    parameter int ORDER = 4,
    parameter int CH    = 2,
    parameter int STEPS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ORDER-1:0]    cfg_taps,
    input  logic [ORDER-1:0]    cfg_seed,
    input  logic                start,
    input  logic                stop,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*STEPS-1:0] out_data,
    output logic                out_sop,
    output logic                lockup_flag
);

    mseq_state_e         state_q, state_d;
    logic [ORDER-1:0]    taps_q;
    logic [ORDER-1:0]    seed_eff_s;
    logic                valid_q;
    logic [CH*STEPS-1:0] data_q;
    logic                sop_q;
    logic                busy_q;
    logic                flag_q;
    logic                load_s;
    logic                adv_s;
    logic                hs_s;
    logic [CH*STEPS-1:0] bits_s;
    logic [CH-1:0]       sop_s;
`ifdef MSEQ_LOCKUP_RECOVER_EN
    logic [CH-1:0]       zero_s;

    assign seed_eff_s = (cfg_seed == {ORDER{1'b0}}) ? {{(ORDER-1){1'b0}}, 1'b1} : cfg_seed;
`else
    assign seed_eff_s = cfg_seed;
`endif

    assign hs_s = valid_q & out_ready;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        mseq_lfsr_ch #(
            .ORDER  (ORDER),
            .STEPS  (STEPS),
            .CH_IDX (c)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .load_i (load_s),
            .adv_i  (adv_s),
            .seed_i (seed_eff_s),
            .taps_i (taps_q),
            .bits_o (bits_s[c*STEPS +: STEPS]),
`ifdef MSEQ_LOCKUP_RECOVER_EN
            .zero_o (zero_s[c]),
`endif
            .sop_o  (sop_s[c])
        );
    end

    // FSM next-state and per-cycle load/advance strobes.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        adv_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else begin
                    adv_s   = !valid_q || out_ready;
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!valid_q || out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Output word register; a presented word is held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_q  <= {ORDER{1'b0}};
            valid_q <= 1'b0;
            data_q  <= {(CH*STEPS){1'b0}};
            sop_q   <= 1'b0;
        end else begin
            if (load_s) begin
                taps_q <= cfg_taps;
            end
            if (adv_s) begin
                data_q  <= bits_s;
                sop_q   <= &sop_s;
                valid_q <= 1'b1;
            end else if (hs_s) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef MSEQ_LOCKUP_RECOVER_EN
    // Sticky lockup indicator, cleared by a new load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else if (load_s) begin
            flag_q <= 1'b0;
        end else if (adv_s && (|zero_s)) begin
            flag_q <= 1'b1;
        end
    end
`else
    assign flag_q = 1'b0;
`endif

    assign busy        = busy_q;
    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_sop     = sop_q;
    assign lockup_flag = flag_q;

endmodule

// File: tb/tb_mseq_gen_mc.sv
// Directed bench: instance A (CH=2,STEPS=1) and instance B (CH=1,STEPS=5), ORDER=4.
module tb_mseq_gen_mc;

    logic       clk;
    logic       rst;
    logic [3:0] cfg_taps;
    logic [3:0] cfg_seed;

    logic       start_a, stop_a, ready_a, busy_a, valid_a, sop_a, flag_a;
    logic [1:0] data_a;
    logic       start_b, stop_b, ready_b, busy_b, valid_b, sop_b, flag_b;
    logic [4:0] data_b;

    int checks;
    int failures;

    // Reference period for taps 1100 / seed 0001, bit i = i-th emitted bit.
    logic [14:0] seq_r;
    logic [4:0]  words_r [3];

    mseq_gen_mc #(.ORDER(4), .CH(2), .STEPS(1)) u_a (
        .clk(clk), .rst(rst), .cfg_taps(cfg_taps), .cfg_seed(cfg_seed),
        .start(start_a), .stop(stop_a), .busy(busy_a), .out_valid(valid_a),
        .out_ready(ready_a), .out_data(data_a), .out_sop(sop_a), .lockup_flag(flag_a)
    );

    mseq_gen_mc #(.ORDER(4), .CH(1), .STEPS(5)) u_b (
        .clk(clk), .rst(rst), .cfg_taps(cfg_taps), .cfg_seed(cfg_seed),
        .start(start_b), .stop(stop_b), .busy(busy_b), .out_valid(valid_b),
        .out_ready(ready_b), .out_data(data_b), .out_sop(sop_b), .lockup_flag(flag_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy_a, valid_a, data_a, sop_a, flag_a} !== 6'b0) begin
            failures++;
            $display("FAIL reset_a got busy=%b valid=%b data=%b sop=%b flag=%b expected all 0",
                     busy_a, valid_a, data_a, sop_a, flag_a);
        end
        checks++;
        if ({busy_b, valid_b, data_b, sop_b, flag_b} !== 9'b0) begin
            failures++;
            $display("FAIL reset_b got busy=%b valid=%b data=%h sop=%b flag=%b expected all 0",
                     busy_b, valid_b, data_b, sop_b, flag_b);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy_a, valid_a, busy_b, valid_b} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy_a=%b valid_a=%b busy_b=%b valid_b=%b expected 0",
                     busy_a, valid_a, busy_b, valid_b);
        end
    endtask

    task automatic test_two_channel_seq();
        int ones;
        logic [1:0] exp_d;
        logic exp_sop;
        ones = 0;
        cfg_taps = 4'b1100;
        cfg_seed = 4'b0001;
        ready_a  = 1'b1;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL load_cycle got valid=%b busy=%b expected valid=0 busy=1", valid_a, busy_a);
        end
        tick();
        checks++;
        if (valid_a !== 1'b0) begin
            failures++;
            $display("FAIL latency_t1 got valid=%b expected 0", valid_a);
        end
        tick();
        for (int i = 0; i < 45; i++) begin
            exp_d   = {seq_r[(i + 1) % 15], seq_r[i % 15]};
            exp_sop = (i % 15 == 0);
            checks++;
            if (valid_a !== 1'b1 || data_a !== exp_d || sop_a !== exp_sop) begin
                failures++;
                $display("FAIL seq2ch word %0d got valid=%b data=%b sop=%b expected valid=1 data=%b sop=%b",
                         i, valid_a, data_a, sop_a, exp_d, exp_sop);
            end
            ones += int'(data_a[0]);
            tick();
        end
        checks++;
        if (ones != 24) begin
            failures++;
            $display("FAIL ones_count got %0d expected 24", ones);
        end
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            failures++;
            $display("FAIL stop_a got busy=%b valid=%b expected 0 0", busy_a, valid_a);
        end
    endtask

    task automatic test_backpressure();
        cfg_taps = 4'b1100;
        cfg_seed = 4'b0001;
        ready_b  = 1'b1;
        start_b  = 1'b1;
        tick();
        start_b  = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (valid_b !== 1'b1 || data_b !== words_r[i] || sop_b !== (i == 0)) begin
                failures++;
                $display("FAIL steps5 word %0d got valid=%b data=%h sop=%b expected data=%h",
                         i, valid_b, data_b, sop_b, words_r[i]);
            end
            if (i == 0) begin
                tick();
            end
        end
        cfg_seed = 4'b1111;
        ready_b  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_b = (i == 1);
            tick();
            checks++;
            if (valid_b !== 1'b1 || data_b !== 5'h16 || sop_b !== 1'b0) begin
                failures++;
                $display("FAIL hold cycle %0d got valid=%b data=%h sop=%b expected 1 16 0",
                         i, valid_b, data_b, sop_b);
            end
        end
        start_b = 1'b0;
        ready_b = 1'b1;
        for (int i = 2; i < 5; i++) begin
            tick();
            checks++;
            if (valid_b !== 1'b1 || data_b !== words_r[i % 3] || sop_b !== (i % 3 == 0)) begin
                failures++;
                $display("FAIL resume word %0d got valid=%b data=%h sop=%b expected data=%h sop=%b",
                         i, valid_b, data_b, sop_b, words_r[i % 3], (i % 3 == 0));
            end
        end
        cfg_seed = 4'b0001;
    endtask

    task automatic test_stop_drain();
        ready_b = 1'b0;
        stop_b  = 1'b1;
        tick();
        stop_b  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy_b !== 1'b1 || valid_b !== 1'b1 || data_b !== 5'h16) begin
                failures++;
                $display("FAIL drain_hold %0d got busy=%b valid=%b data=%h expected 1 1 16",
                         i, busy_b, valid_b, data_b);
            end
            tick();
        end
        ready_b = 1'b1;
        tick();
        checks++;
        if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL drain_done got busy=%b valid=%b expected 0 0", busy_b, valid_b);
        end
        start_b = 1'b1;
        stop_b  = 1'b1;
        tick();
        start_b = 1'b0;
        stop_b  = 1'b0;
        tick();
        tick();
        checks++;
        if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_idle got busy=%b valid=%b expected 0 0", busy_b, valid_b);
        end
    endtask

    task automatic test_restart();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        tick();
        checks++;
        if (valid_b !== 1'b1 || data_b !== 5'h08 || sop_b !== 1'b1) begin
            failures++;
            $display("FAIL restart got valid=%b data=%h sop=%b expected 1 08 1", valid_b, data_b, sop_b);
        end
        stop_b = 1'b1;
        tick();
        stop_b = 1'b0;
        tick();
        checks++;
        if (busy_b !== 1'b0) begin
            failures++;
            $display("FAIL restart_stop got busy=%b expected 0", busy_b);
        end
    endtask

    task automatic test_zero_seed();
        cfg_taps = 4'b1100;
        cfg_seed = 4'b0000;
        ready_a  = 1'b1;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
`ifdef MSEQ_LOCKUP_RECOVER_EN
            checks++;
            if (valid_a !== 1'b1 || data_a !== {seq_r[(i + 1) % 15], seq_r[i % 15]} || flag_a !== 1'b0) begin
                failures++;
                $display("FAIL zero_seed_recover %0d got data=%b flag=%b", i, data_a, flag_a);
            end
`else
            checks++;
            if (valid_a !== 1'b1 || data_a !== 2'b00 || flag_a !== 1'b0) begin
                failures++;
                $display("FAIL zero_seed %0d got valid=%b data=%b flag=%b expected 1 00 0",
                         i, valid_a, data_a, flag_a);
            end
`endif
            tick();
        end
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        tick();
`ifdef MSEQ_LOCKUP_RECOVER_EN
        cfg_taps = 4'b0001;
        cfg_seed = 4'b0001;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        checks++;
        if (flag_a !== 1'b1 || valid_a !== 1'b1) begin
            failures++;
            $display("FAIL lockup_flag got flag=%b valid=%b expected 1 1", flag_a, valid_a);
        end
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        tick();
`endif
        cfg_taps = 4'b1100;
        cfg_seed = 4'b0001;
    endtask

    task automatic test_reset_mid();
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checks++;
        if (valid_a !== 1'b1 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_run got valid=%b busy=%b expected 1 1", valid_a, busy_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_a, valid_a, data_a, sop_a, flag_a} !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b valid=%b data=%b sop=%b flag=%b expected all 0",
                     busy_a, valid_a, data_a, sop_a, flag_a);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got busy=%b valid=%b expected 0 0", busy_a, valid_a);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        seq_r      = 15'b111101011001000;
        words_r[0] = 5'h08;
        words_r[1] = 5'h16;
        words_r[2] = 5'h1E;
        rst        = 1'b1;
        cfg_taps   = 4'b1100;
        cfg_seed   = 4'b0001;
        start_a    = 1'b0;
        stop_a     = 1'b0;
        ready_a    = 1'b0;
        start_b    = 1'b0;
        stop_b     = 1'b0;
        ready_b    = 1'b0;
        test_reset();
        test_two_channel_seq();
        test_backpressure();
        test_stop_drain();
        test_restart();
        test_zero_seed();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
